// File: rtl/lstm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : lstm_pkg                                                          |
// | Purpose  : Shared requester ids, arbiter state encoding and return-tag type. |
// | Revision : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package lstm_pkg;

   localparam logic [1:0] REQ_GATE = 2'd0;
   localparam logic [1:0] REQ_FC   = 2'd1;
   localparam logic [1:0] REQ_BIAS = 2'd2;
   localparam int         NUM_REQ  = 3;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_ISSUE = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic       vld;
      logic [1:0] owner;
      logic       last;
   } rd_tag_t;

   // First requesting index at or after ptr, wrapping over 0..2.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
      logic [2:0] s;
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         s   = {1'b0, ptr} + 3'(i);
         idx = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   function automatic logic [1:0] rr_next(input logic [1:0] owner);
      return (owner == REQ_BIAS) ? REQ_GATE : owner + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_rd_tag_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lstm_rd_tag_pipe                                                  |
// | Purpose  : DEPTH-stage shift register of read return tags, cleared by reset. |
// | Revision : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lstm_rd_tag_pipe
   import lstm_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] tag_in,
   output logic [3:0] tag_out,
   output logic       any_vld
);

   rd_tag_t r_stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      end else begin
         r_stage[0] <= rd_tag_t'(tag_in);
         for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      end
   end

   always_comb begin
      any_vld = 1'b0;
      for (int k = 0; k < DEPTH; k++) any_vld = any_vld | r_stage[k].vld;
   end

   assign tag_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/lstm_wmem_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lstm_wmem_rd_arbiter                                              |
// | Purpose  : Round-robin burst arbiter for the LSTM weight-store read port.    |
// |            Define LSTM_ARB_PERF_EN to add perf_beats / perf_stall counters.  |
// | Revision : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lstm_wmem_rd_arbiter
   import lstm_pkg::*;
#(
   parameter int AW     = 20,
   parameter int DW     = 96,
   parameter int LW     = 8,
   parameter int RD_LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      req,
   input  logic [3*AW-1:0] req_adr,
   input  logic [3*LW-1:0] req_len,
   output logic [2:0]      gnt,
   input  logic            mem_ready,
   output logic            mem_rd_en,
   output logic [AW-1:0]   mem_adr,
   input  logic [DW-1:0]   mem_rdata,
   output logic [DW-1:0]   rd_data,
   output logic [2:0]      rd_valid,
   output logic [2:0]      rd_done,
   output logic            busy
`ifdef LSTM_ARB_PERF_EN
   ,
   output logic [3*32-1:0] perf_beats,
   output logic [31:0]     perf_stall
`endif
);

   arb_state_t    r_state, w_state_nxt;
   logic [AW-1:0] r_adr;
   logic [LW-1:0] r_len, r_cnt;
   logic [1:0]    r_owner, r_rr_ptr, w_pick;
   logic [2:0]    w_gnt;
   logic          w_accept, w_last;
   logic [AW-1:0] w_req_adr [NUM_REQ];
   logic [LW-1:0] w_req_len [NUM_REQ];
   logic [3:0]    w_tag_out_bits;
   rd_tag_t       w_tag_in, w_tag_out;
   logic          w_tag_any;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_req_adr[i] = req_adr[i*AW +: AW];
      assign w_req_len[i] = req_len[i*LW +: LW];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ARB_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_pick      = rr_pick(req, r_rr_ptr);
      w_state_nxt = r_state;
      w_gnt       = 3'b000;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (|req) begin
               w_gnt       = 3'b001 << w_pick;
               w_state_nxt = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            w_accept = mem_ready;
            w_last   = mem_ready && (r_cnt == r_len);
            if (w_last) w_state_nxt = ARB_IDLE;
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   // Combinational strobes are masked so nothing leaks out during the reset cycle.
   assign gnt       = rst_n ? w_gnt : 3'b000;
   assign mem_rd_en = rst_n & w_accept;
   assign mem_adr   = r_adr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_adr    <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_owner  <= REQ_GATE;
         r_rr_ptr <= REQ_GATE;
      end else if (w_gnt != 3'b000) begin
         r_adr   <= w_req_adr[w_pick];
         r_len   <= w_req_len[w_pick];
         r_cnt   <= '0;
         r_owner <= w_pick;
      end else if (w_accept) begin
         r_adr <= r_adr + AW'(1);
         r_cnt <= r_cnt + LW'(1);
         if (w_last) r_rr_ptr <= rr_next(r_owner);
      end
   end

   assign w_tag_in = '{vld: mem_rd_en, owner: r_owner, last: w_last};

   lstm_rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (w_tag_in),
      .tag_out (w_tag_out_bits),
      .any_vld (w_tag_any)
   );

   assign w_tag_out = rd_tag_t'(w_tag_out_bits);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid <= 3'b000;
         rd_done  <= 3'b000;
         rd_data  <= '0;
      end else begin
         rd_valid <= w_tag_out.vld ? (3'b001 << w_tag_out.owner) : 3'b000;
         rd_done  <= (w_tag_out.vld && w_tag_out.last) ? (3'b001 << w_tag_out.owner) : 3'b000;
         if (w_tag_out.vld) rd_data <= mem_rdata;
      end
   end

   assign busy = rst_n & ((r_state != ARB_IDLE) | w_tag_any);

`ifdef LSTM_ARB_PERF_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
      logic [31:0] r_beats;
      always_ff @(posedge clk) begin
         if (!rst_n)
            r_beats <= '0;
         else if (mem_rd_en && (r_owner == 2'(i)) && (r_beats != '1))
            r_beats <= r_beats + 32'd1;
      end
      assign perf_beats[i*32 +: 32] = r_beats;
   end

   logic [31:0] r_perf_stall;
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_perf_stall <= '0;
      else if ((r_state == ARB_ISSUE) && !mem_ready && (r_perf_stall != '1))
         r_perf_stall <= r_perf_stall + 32'd1;
   end
   assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lstm_wmem_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_lstm_wmem_rd_arbiter                                           |
// | Purpose  : Directed + random bench with a transaction-level reference model. |
// | Revision : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_lstm_wmem_rd_arbiter;

   localparam int AW     = 20;
   localparam int DW     = 96;
   localparam int LW     = 8;
   localparam int RD_LAT = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      req = 3'b000;
   logic [3*AW-1:0] req_adr = '0;
   logic [3*LW-1:0] req_len = '0;
   logic            mem_ready = 1'b1;
   logic [DW-1:0]   mem_rdata;
   logic [2:0]      gnt, rd_valid, rd_done;
   logic            mem_rd_en, busy;
   logic [AW-1:0]   mem_adr;
   logic [DW-1:0]   rd_data;
`ifdef LSTM_ARB_PERF_EN
   logic [95:0]     perf_beats;
   logic [31:0]     perf_stall;
`endif

   always #5 clk = ~clk;

   lstm_wmem_rd_arbiter #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_adr   (req_adr),
      .req_len   (req_len),
      .gnt       (gnt),
      .mem_ready (mem_ready),
      .mem_rd_en (mem_rd_en),
      .mem_adr   (mem_adr),
      .mem_rdata (mem_rdata),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_done   (rd_done),
      .busy      (busy)
`ifdef LSTM_ARB_PERF_EN
      ,
      .perf_beats(perf_beats),
      .perf_stall(perf_stall)
`endif
   );

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   logic   rnd_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {~{12'h000, a}, 32'h5A5A0000 ^ {12'h000, a}, {a, 12'h3C5}};
   endfunction

   // Memory: returns pat(addr) exactly RD_LAT cycles after an accepted strobe.
   logic [RD_LAT-1:0] mp_vld = '0;
   logic [AW-1:0]     mp_adr [RD_LAT];
   always @(posedge clk) begin
      mp_vld[0] <= mem_rd_en;
      mp_adr[0] <= mem_adr;
      for (int k = 1; k < RD_LAT; k++) begin
         mp_vld[k] <= mp_vld[k-1];
         mp_adr[k] <= mp_adr[k-1];
      end
   end
   always_comb mem_rdata = mp_vld[RD_LAT-1] ? pat(mp_adr[RD_LAT-1]) : {3{32'hDEADBEEF}};

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: beats still to issue, and returns awaiting their cycle.
   typedef struct { logic [AW-1:0] adr; logic [1:0] own; logic last; } beat_t;
   typedef struct { longint due; logic [AW-1:0] adr; logic [1:0] own; logic last; } ret_t;
   beat_t  sq[$];
   ret_t   rq[$];
   int     rr = 0;
   longint m_beats [3];
   longint m_stall = 0;

   int     obs_strobes = 0;
   int     obs_valid [3];
   int     obs_done [3];
   int     obs_gnt [3];
   int     gnt_order[$];
   longint strobe_cycs[$];
   longint valid_cycs[$];
   logic [AW-1:0] strobe_adrs[$];
   longint gnt_cyc = 0;
   longint done_cyc = 0;

   function automatic int model_pick(input logic [2:0] r);
      for (int k = 0; k < 3; k++)
         if (r[(rr + k) % 3]) return (rr + k) % 3;
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [2:0]    eg, ev, ed;
      logic          een, ebusy;
      int            p;
      beat_t         b;
      ret_t          r;
      logic [AW-1:0] base;
      logic [LW-1:0] len;
      if (!rst_n) begin
         chk("gnt_in_reset", gnt, 0);
         chk("rd_en_in_reset", mem_rd_en, 0);
         sq.delete();
         rq.delete();
         rr = 0;
         m_beats = '{0, 0, 0};
         m_stall = 0;
      end else begin
         eg = 3'b000;
         p  = model_pick(req);
         if (sq.size() == 0 && p >= 0) eg = 3'b001 << p;
         chk("gnt", gnt, eg);
         een = (sq.size() != 0) && mem_ready;
         chk("mem_rd_en", mem_rd_en, een);
         ebusy = (sq.size() != 0) || (rq.size() != 0 && rq[rq.size()-1].due > cyc);
         chk("busy", busy, ebusy);
         ev = 3'b000;
         ed = 3'b000;
         if (rq.size() != 0 && rq[0].due == cyc) begin
            r  = rq.pop_front();
            ev = 3'b001 << r.own;
            if (r.last) ed = ev;
            chk("rd_data", rd_data, pat(r.adr));
         end
         chk("rd_valid", rd_valid, ev);
         chk("rd_done", rd_done, ed);
         if (sq.size() != 0 && !mem_ready) m_stall++;
         if (een && mem_rd_en === 1'b1) begin
            b = sq.pop_front();
            chk("mem_adr", mem_adr, b.adr);
            r.due = cyc + RD_LAT + 1;
            r.adr = b.adr;
            r.own = b.own;
            r.last = b.last;
            rq.push_back(r);
            m_beats[b.own]++;
            if (b.last) rr = (b.own + 1) % 3;
         end
         if (eg != 3'b000) begin
            base = req_adr[p*AW +: AW];
            len  = req_len[p*LW +: LW];
            for (int k = 0; k <= int'(len); k++) begin
               b.adr  = base + AW'(k);
               b.own  = 2'(p);
               b.last = (k == int'(len));
               sq.push_back(b);
            end
         end
         // Raw observations for the directed scenario checks.
         if (mem_rd_en === 1'b1) begin
            obs_strobes++;
            strobe_cycs.push_back(cyc);
            strobe_adrs.push_back(mem_adr);
         end
         for (int i = 0; i < 3; i++) begin
            if (rd_valid[i] === 1'b1) begin obs_valid[i]++; valid_cycs.push_back(cyc); end
            if (rd_done[i] === 1'b1) begin obs_done[i]++; done_cyc = cyc; end
            if (gnt[i] === 1'b1) begin obs_gnt[i]++; gnt_order.push_back(i); gnt_cyc = cyc; end
         end
      end
   end

   task automatic step();
      logic [2:0] g;
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      req = req & ~g;
      if (rnd_rdy) mem_ready = ($urandom_range(3) != 0);
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_adr[i*AW +: AW] = a;
      req_len[i*LW +: LW] = l;
      req[i] = 1'b1;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while ((req != 3'b000 || busy !== 1'b0 || sq.size() != 0 || rq.size() != 0) && n < budget) begin
         step();
         n++;
      end
      chk({"idle_", tag}, (n < budget), 1'b1);
      step();
   endtask

   task automatic clear_obs();
      gnt_order.delete();
      strobe_cycs.delete();
      valid_cycs.delete();
      strobe_adrs.delete();
   endtask

   initial begin
      int base_s, base_v1, base_d1, base_g1, n;
      m_beats = '{0, 0, 0};
      obs_valid = '{0, 0, 0};
      obs_done  = '{0, 0, 0};
      obs_gnt   = '{0, 0, 0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_done", rd_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_adr", mem_adr, 0);
      chk("rst_rd_data", rd_data, 0);
      @(posedge clk);
      #1;

      // All three at once from reset: 0,1,2; then 0+2: 0,2.
      clear_obs();
      set_req(0, 20'h01000, 8'd1);
      set_req(1, 20'h02000, 8'd0);
      set_req(2, 20'h03000, 8'd2);
      wait_idle(100, "t2a");
      chk("t2a_ngnt", gnt_order.size(), 3);
      if (gnt_order.size() == 3) begin
         chk("t2a_order0", gnt_order[0], 0);
         chk("t2a_order1", gnt_order[1], 1);
         chk("t2a_order2", gnt_order[2], 2);
      end
      clear_obs();
      set_req(0, 20'h01100, 8'd0);
      set_req(2, 20'h03100, 8'd0);
      wait_idle(100, "t2b");
      chk("t2b_ngnt", gnt_order.size(), 2);
      if (gnt_order.size() == 2) begin
         chk("t2b_order0", gnt_order[0], 0);
         chk("t2b_order1", gnt_order[1], 2);
      end

      // Single burst timing.
      clear_obs();
      set_req(0, 20'h00100, 8'd3);
      wait_idle(100, "t1");
      chk("t1_nstrobe", strobe_cycs.size(), 4);
      chk("t1_nvalid", valid_cycs.size(), 4);
      if (strobe_cycs.size() == 4 && valid_cycs.size() == 4) begin
         chk("t1_first_strobe", strobe_cycs[0] - gnt_cyc, 1);
         chk("t1_last_strobe", strobe_cycs[3] - gnt_cyc, 4);
         chk("t1_first_valid", valid_cycs[0] - gnt_cyc, 4);
         chk("t1_adr3", strobe_adrs[3], 20'h00103);
      end
      chk("t1_done", done_cyc - gnt_cyc, 7);

      // Stall of 3 cycles mid-burst.
      clear_obs();
      base_s = obs_strobes;
      set_req(0, 20'h02000, 8'd7);
      n = 0;
      while (obs_strobes - base_s < 3 && n < 20) begin step(); n++; end
      chk("t3_reach", n < 20, 1'b1);
      mem_ready = 1'b0;
      repeat (3) begin
         step();
         chk("t3_adr_hold", mem_adr, 20'h02003);
      end
      mem_ready = 1'b1;
      wait_idle(100, "t3");
      chk("t3_nstrobe", strobe_cycs.size(), 8);
      chk("t3_nvalid", valid_cycs.size(), 8);
      if (strobe_cycs.size() == 8) chk("t3_span", strobe_cycs[7] - gnt_cyc, 11);

      // Address wrap.
      clear_obs();
      set_req(2, 20'hFFFFE, 8'd3);
      wait_idle(100, "t4");
      chk("t4_n", strobe_adrs.size(), 4);
      if (strobe_adrs.size() == 4) begin
         chk("t4_a0", strobe_adrs[0], 20'hFFFFE);
         chk("t4_a1", strobe_adrs[1], 20'hFFFFF);
         chk("t4_a2", strobe_adrs[2], 20'h00000);
         chk("t4_a3", strobe_adrs[3], 20'h00001);
      end

      // Reset mid-burst discards in-flight beats.
      base_s = obs_strobes;
      set_req(0, 20'h00300, 8'd5);
      n = 0;
      while (obs_strobes - base_s < 2 && n < 20) begin step(); n++; end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      base_v1 = obs_valid[0] + obs_done[0];
      @(negedge clk);
      chk("t5_busy_after", busy, 0);
      @(posedge clk);
      #1;
      repeat (4) step();
      chk("t5_no_return", obs_valid[0] + obs_done[0] - base_v1, 0);
      clear_obs();
      set_req(1, 20'h00400, 8'd2);
      set_req(2, 20'h00500, 8'd0);
      wait_idle(100, "t5");
      chk("t5_ngnt", gnt_order.size(), 2);
      if (gnt_order.size() == 2) chk("t5_first", gnt_order[0], 1);

      // Withdrawn request is never granted.
      base_g1 = obs_gnt[1];
      base_v1 = obs_valid[1];
      base_d1 = obs_done[1];
      set_req(0, 20'h00600, 8'd6);
      step();
      step();
      set_req(1, 20'h00700, 8'd1);
      step();
      step();
      req[1] = 1'b0;
      wait_idle(100, "t6");
      chk("t6_no_gnt1", obs_gnt[1] - base_g1, 0);
      chk("t6_no_valid1", obs_valid[1] + obs_done[1] - base_v1 - base_d1, 0);

      // Maximum burst length.
      base_s = obs_strobes;
      base_d1 = obs_done[1];
      set_req(1, 20'h07000, 8'hFF);
      wait_idle(400, "t7");
      chk("t7_nstrobe", obs_strobes - base_s, 256);
      chk("t7_ndone", obs_done[1] - base_d1, 1);

      // Random traffic with random memory backpressure.
      rnd_rdy = 1'b1;
      for (int t = 0; t < 800; t++) begin
         for (int i = 0; i < 3; i++) begin
            if (!req[i] && $urandom_range(7) == 0)
               set_req(i, AW'($urandom), LW'($urandom_range(5)));
            else if (req[i] && $urandom_range(39) == 0)
               req[i] = 1'b0;
         end
         step();
      end
      wait_idle(200, "rand");
      rnd_rdy = 1'b0;
      mem_ready = 1'b1;

`ifdef LSTM_ARB_PERF_EN
      for (int i = 0; i < 3; i++) chk("perf_beats", perf_beats[i*32 +: 32], 96'(m_beats[i]));
      chk("perf_stall", perf_stall, 96'(m_stall));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
